// File: rtl/instr_entry_pkg.sv
// Shared types and constants for the instruction-entry path.
package instr_entry_pkg;

  // Entry progress: nothing keyed, partially keyed, all eight nibbles keyed.
  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    FULL
  } entry_state_t;

  // Number of hex nibbles in one RV32I instruction word.
  localparam int unsigned NIBBLES = 8;

  // ADDI x0,x0,0: a harmless word for immGen before anything is committed.
  localparam logic [31:0] RV_NOP = 32'h00000013;

  // Shift one nibble into the low end of the word being keyed.
  function automatic logic [31:0] shift_nibble(input logic [31:0] word, input logic [3:0] nib);
    return {word[27:0], nib};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, debounce filter and a
// one-cycle press pulse on the released->pressed transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  // Counting from 0, the level flips on the edge where the count would hit DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;   // active-low, synchronized raw level
  logic            level_q, level_d;   // debounced level, 1 = pressed
  logic            level_d1_q;         // previous debounced level for edge detect
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q;
  logic            differs;

  assign differs = (~sync2_q) != level_q;

  // Debounce counter: runs only while the synchronized level disagrees.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (differs) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State registers; reset forces the released level so no pending press survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      level_q    <= 1'b0;
      level_d1_q <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      level_d1_q <= level_q;
      cnt_q      <= cnt_d;
      press_q    <= level_q & ~level_d1_q;
    end
  end

  assign pressed = level_q;
  assign press   = press_q;

endmodule

// File: rtl/instr_entry.sv
// Keys a 32-bit instruction in eight hex nibbles from the board switches and
// commits it to immGen; the in-progress word feeds the 7-segment display.
module instr_entry
  import instr_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] RESET_INSTR     = RV_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        key_push_n,
  input  logic        key_commit_n,
  input  logic        key_clear_n,
  output logic [31:0] entry,
  output logic [3:0]  nib_cnt,
  output logic        full,
  output logic [31:0] instr,
  output logic        commit_valid,
  output logic        ovf,
  output logic        err
);

  logic push_p, commit_p, clear_p;
  logic push_lvl, commit_lvl, clear_lvl;
  logic unused_levels;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push_key (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_push_n),
    .pressed (push_lvl),
    .press   (push_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_key (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_commit_n),
    .pressed (commit_lvl),
    .press   (commit_p)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_clear_n),
    .pressed (clear_lvl),
    .press   (clear_p)
  );

  // Held levels are not needed here; only the press pulses drive the FSM.
  assign unused_levels = push_lvl ^ commit_lvl ^ clear_lvl;

  logic [3:0]   sw_s1_q, sw_s2_q;
  entry_state_t state_q, state_d;
  logic [31:0]  entry_q, entry_d;
  logic [3:0]   nib_cnt_q, nib_cnt_d;
  logic [31:0]  instr_q, instr_d;
  logic         ovf_q, ovf_d;
  logic         commit_valid_q, commit_valid_d;
  logic         err_q, err_d;

  // Switch synchronizer; the nibble is taken in the same cycle as the push pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  // Next-state logic; clear beats commit beats push when pulses coincide.
  always_comb begin
    state_d        = state_q;
    entry_d        = entry_q;
    nib_cnt_d      = nib_cnt_q;
    instr_d        = instr_q;
    ovf_d          = ovf_q;
    commit_valid_d = 1'b0;
    err_d          = 1'b0;

    if (clear_p) begin
      entry_d   = '0;
      nib_cnt_d = '0;
      ovf_d     = 1'b0;
      state_d   = EMPTY;
    end else if (commit_p) begin
      if (state_q == FULL) begin
        instr_d        = entry_q;
        commit_valid_d = 1'b1;
        entry_d        = '0;
        nib_cnt_d      = '0;
        ovf_d          = 1'b0;
        state_d        = EMPTY;
      end else begin
        err_d = 1'b1;
      end
    end else if (push_p) begin
      case (state_q)
        EMPTY, ENTRY: begin
          entry_d   = shift_nibble(entry_q, sw_s2_q);
          nib_cnt_d = nib_cnt_q + 4'd1;
          state_d   = (nib_cnt_q == 4'(NIBBLES - 1)) ? FULL : ENTRY;
        end
        FULL: begin
          ovf_d = 1'b1;
        end
        default: begin
          // Unreachable encoding: recover to a clean empty entry.
          entry_d   = '0;
          nib_cnt_d = '0;
          state_d   = EMPTY;
        end
      endcase
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      entry_q        <= '0;
      nib_cnt_q      <= '0;
      instr_q        <= RESET_INSTR;
      ovf_q          <= 1'b0;
      commit_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      entry_q        <= entry_d;
      nib_cnt_q      <= nib_cnt_d;
      instr_q        <= instr_d;
      ovf_q          <= ovf_d;
      commit_valid_q <= commit_valid_d;
      err_q          <= err_d;
    end
  end

  assign full         = (state_q == FULL);
  assign entry        = entry_q;
  assign nib_cnt      = nib_cnt_q;
  assign instr        = instr_q;
  assign ovf          = ovf_q;
  assign commit_valid = commit_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_instr_entry.sv
// Directed bench for instr_entry with a short debounce window (latency 8 edges).
module tb_instr_entry;

  localparam int unsigned Db  = 4;
  localparam int unsigned Lat = Db + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sw = 4'h0;
  logic        key_push_n = 1'b1;
  logic        key_commit_n = 1'b1;
  logic        key_clear_n = 1'b1;
  logic [31:0] entry;
  logic [3:0]  nib_cnt;
  logic        full;
  logic [31:0] instr;
  logic        commit_valid;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  instr_entry #(
    .DEBOUNCE_CYCLES(Db),
    .RESET_INSTR    (32'h00000013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw           (sw),
    .key_push_n   (key_push_n),
    .key_commit_n (key_commit_n),
    .key_clear_n  (key_clear_n),
    .entry        (entry),
    .nib_cnt      (nib_cnt),
    .full         (full),
    .instr        (instr),
    .commit_valid (commit_valid),
    .ovf          (ovf),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Advance n edges; sampling and driving happen 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_keys();
    key_push_n   = 1'b1;
    key_commit_n = 1'b1;
    key_clear_n  = 1'b1;
    tick(12);
  endtask

  task automatic push_nib(input logic [3:0] v);
    sw = v;
    tick(3);
    key_push_n = 1'b0;
    tick(Lat);
    release_keys();
  endtask

  task automatic clear_entry();
    key_clear_n = 1'b0;
    tick(Lat);
    release_keys();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (instr !== 32'h00000013 || entry !== 32'h0 || nib_cnt !== 4'd0 || full !== 1'b0 ||
          commit_valid !== 1'b0 || ovf !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: instr=%h entry=%h cnt=%0d full=%b cv=%b ovf=%b err=%b",
                 i, instr, entry, nib_cnt, full, commit_valid, ovf, err);
      end
      tick(1);
    end
  endtask

  task automatic test_entry_commit();
    logic [3:0] nibs [8];
    nibs = '{4'hf, 4'hf, 4'h9, 4'hf, 4'hf, 4'h0, 4'h6, 4'hf};
    for (int i = 0; i < 8; i++) push_nib(nibs[i]);
    checks++;
    if (entry !== 32'hff9ff06f || nib_cnt !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL eight_push: entry=%h cnt=%0d full=%b, want ff9ff06f 8 1", entry, nib_cnt, full);
    end
    key_commit_n = 1'b0;
    tick(Lat - 1);
    checks++;
    if (commit_valid !== 1'b0 || instr !== 32'h00000013) begin
      errors++;
      $display("FAIL commit_early: cv=%b instr=%h, want 0 00000013", commit_valid, instr);
    end
    tick(1);
    checks++;
    if (commit_valid !== 1'b1 || instr !== 32'hff9ff06f || entry !== 32'h0 || nib_cnt !== 4'd0 ||
        full !== 1'b0) begin
      errors++;
      $display("FAIL commit_edge: cv=%b instr=%h entry=%h cnt=%0d full=%b, want 1 ff9ff06f 0 0 0",
               commit_valid, instr, entry, nib_cnt, full);
    end
    tick(1);
    checks++;
    if (commit_valid !== 1'b0 || instr !== 32'hff9ff06f) begin
      errors++;
      $display("FAIL commit_pulse_width: cv=%b instr=%h, want 0 ff9ff06f", commit_valid, instr);
    end
    release_keys();
  endtask

  task automatic test_bounce_sample();
    sw = 4'h3;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      key_push_n = ~key_push_n;
      tick(2);
    end
    key_push_n = 1'b1;
    tick(12);
    checks++;
    if (nib_cnt !== 4'd0 || entry !== 32'h0) begin
      errors++;
      $display("FAIL bounce: cnt=%0d entry=%h, want 0 0", nib_cnt, entry);
    end
    sw = 4'ha;
    tick(3);
    key_push_n = 1'b0;
    tick(Lat - 1);
    checks++;
    if (entry !== 32'h0) begin
      errors++;
      $display("FAIL push_early: entry=%h, want 00000000", entry);
    end
    tick(1);
    checks++;
    if (entry !== 32'h0000000a || nib_cnt !== 4'd1) begin
      errors++;
      $display("FAIL push_sample: entry=%h cnt=%0d, want 0000000a 1", entry, nib_cnt);
    end
    release_keys();
    clear_entry();
    checks++;
    if (entry !== 32'h0 || nib_cnt !== 4'd0 || instr !== 32'hff9ff06f) begin
      errors++;
      $display("FAIL clear: entry=%h cnt=%0d instr=%h, want 0 0 ff9ff06f", entry, nib_cnt, instr);
    end
  endtask

  task automatic test_boundaries();
    for (int i = 1; i <= 8; i++) push_nib(4'(i));
    checks++;
    if (ovf !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_before: ovf=%b full=%b, want 0 1", ovf, full);
    end
    push_nib(4'h9);
    checks++;
    if (entry !== 32'h12345678 || nib_cnt !== 4'd8 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: entry=%h cnt=%0d ovf=%b, want 12345678 8 1", entry, nib_cnt, ovf);
    end
    key_commit_n = 1'b0;
    tick(Lat);
    checks++;
    if (ovf !== 1'b0 || instr !== 32'h12345678 || commit_valid !== 1'b1) begin
      errors++;
      $display("FAIL commit_clears_ovf: ovf=%b instr=%h cv=%b, want 0 12345678 1",
               ovf, instr, commit_valid);
    end
    release_keys();
    push_nib(4'ha);
    push_nib(4'hb);
    push_nib(4'hc);
    key_commit_n = 1'b0;
    tick(Lat - 1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_early: err=%b, want 0", err);
    end
    tick(1);
    checks++;
    if (err !== 1'b1 || instr !== 32'h12345678 || nib_cnt !== 4'd3 || entry !== 32'h00000abc ||
        commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL short_commit: err=%b instr=%h cnt=%0d entry=%h cv=%b, want 1 12345678 3 abc 0",
               err, instr, nib_cnt, entry, commit_valid);
    end
    tick(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err=%b, want 0", err);
    end
    release_keys();
    clear_entry();
  endtask

  task automatic test_clear_vs_commit();
    for (int i = 8; i >= 1; i--) push_nib(4'(i));
    checks++;
    if (entry !== 32'h87654321 || full !== 1'b1) begin
      errors++;
      $display("FAIL refill: entry=%h full=%b, want 87654321 1", entry, full);
    end
    key_clear_n  = 1'b0;
    key_commit_n = 1'b0;
    tick(Lat);
    checks++;
    if (entry !== 32'h0 || nib_cnt !== 4'd0 || instr !== 32'h12345678 || commit_valid !== 1'b0 ||
        err !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_beats_commit: entry=%h cnt=%0d instr=%h cv=%b err=%b full=%b",
               entry, nib_cnt, instr, commit_valid, err, full);
    end
    tick(1);
    checks++;
    if (commit_valid !== 1'b0 || instr !== 32'h12345678) begin
      errors++;
      $display("FAIL clear_beats_commit_after: cv=%b instr=%h, want 0 12345678", commit_valid, instr);
    end
    release_keys();
  endtask

  task automatic test_reset_midpress();
    int bad = 0;
    sw = 4'h5;
    tick(3);
    key_push_n = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    key_push_n = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (nib_cnt !== 4'd0 || entry !== 32'h0) bad++;
      tick(1);
    end
    checks++;
    if (bad != 0 || entry !== 32'h0 || instr !== 32'h00000013 || nib_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_midpress: bad_cycles=%0d entry=%h cnt=%0d instr=%h, want 0 0 0 00000013",
               bad, entry, nib_cnt, instr);
    end
  endtask

  initial begin
    test_reset();
    test_entry_commit();
    test_bounce_sample();
    test_boundaries();
    test_clear_vs_commit();
    test_reset_midpress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_entry.md
Name: instr_entry

Overview:
- Board-level input path for the FPGA hardware bench. Converts the user's switch and pushbutton activity into a 32-bit RV32I instruction word.
- Replaces the hard-coded instruction constant currently fed to immGen: the user keys in eight hex nibbles and then commits them.
- Drives the committed word to immGen and the in-progress word to the 7-segment display chain (binto7seg x8).

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a key level is accepted (10 ms at 50 MHz; benches use 4).
- RESET_INSTR, 32'h00000013, committed word after reset (ADDI x0,x0,0 / NOP).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  4  hex nibble from board switches, sampled at push time.
- key_push_n  in  1  raw pushbutton, active-low, asynchronous: append nibble.
- key_commit_n  in  1  raw pushbutton, active-low, asynchronous: commit word.
- key_clear_n  in  1  raw pushbutton, active-low, asynchronous: clear entry.
- entry  out  32  in-progress word, for display.
- nib_cnt  out  4  nibbles entered, 0..8.
- full  out  1  nib_cnt == 8.
- instr  out  32  committed instruction, to immGen.
- commit_valid  out  1  one-cycle pulse when instr updates.
- ovf  out  1  sticky: a push was attempted while full.
- err  out  1  one-cycle pulse: commit attempted while not full.

Behaviour:
- Reset values (synchronous on rst=1):
  - entry=0, nib_cnt=0, full=0, ovf=0, err=0, commit_valid=0, instr=RESET_INSTR.
  - Debouncers reset to the "released" level with their counters at 0.
  - Reset has priority over every other event, including an in-flight key press: no pulse is generated from a press that was pending at reset.
- Key path (per key), fixed latency:
  - Two-flop synchronizer.
  - Debounce counter: counts while the synchronized level differs from the debounced level; resets to 0 whenever they match. When the count reaches DEBOUNCE_CYCLES, the debounced level flips.
  - Press pulse: one cycle, registered on the debounced released->pressed transition.
  - Latency: a raw press held stable changes architectural state exactly DEBOUNCE_CYCLES+4 clk edges after the first edge sampling it low.
  - Release generates no event. A bounce shorter than DEBOUNCE_CYCLES generates nothing.
- sw is sampled through its own two-flop synchronizer. The value used is the synchronized sw in the same cycle as the push pulse.
- State machine (enum in package):
  - EMPTY: nib_cnt==0.
  - ENTRY: 1..7 nibbles.
  - FULL: 8 nibbles.
- Push:
  - In EMPTY or ENTRY: entry <= {entry[27:0], sw}, nib_cnt+1. Transition to FULL at 8, otherwise to ENTRY.
  - In FULL: no change to entry; ovf <= 1.
- Commit:
  - In FULL: instr <= entry; commit_valid pulses on the same edge instr updates; entry/nib_cnt cleared; state -> EMPTY; ovf cleared.
  - In EMPTY or ENTRY: err pulses one cycle; no other change.
- Clear: entry=0, nib_cnt=0, ovf=0, state -> EMPTY. instr is untouched.
- Simultaneous pulses in the same cycle: priority is clear > commit > push. Only the highest-priority event takes effect.
- full is combinational from state. All other outputs are registered.
- instr holds its value indefinitely until the next valid commit.

Decomposition:
- Package instr_entry_pkg:
  - typedef enum logic [1:0] {EMPTY, ENTRY, FULL} entry_state_t
  - localparam NIBBLES = 8
  - localparam logic [31:0] RV_NOP = 32'h00000013 (default for RESET_INSTR)
- One sub-module: key_debounce.
  - Parameters: DEBOUNCE_CYCLES.
  - Ports: clk, rst, key_n, pressed (level), press (one-cycle pulse).
  - Instantiated three times.
- sw synchronizer and FSM stay inline in instr_entry.

Test Plan (DEBOUNCE_CYCLES=4, latency 8):
1. Reset, no keys -> instr=32'h00000013, entry=0, nib_cnt=0, all pulses 0 for 100 cycles.
2. Enter nibbles f,f,9,f,f,0,6,f (clean presses, sw stable), then commit:
   - After the 8th push: entry=32'hff9ff06f, nib_cnt=8, full=1.
   - On commit: instr=32'hff9ff06f, commit_valid high exactly 1 cycle, 8 edges after commit press; entry=0, nib_cnt=0.
3. Bounce and sampling:
   - key_push_n toggles every 2 cycles for 20 cycles, then releases -> no push recorded.
   - A stable press with sw=4'ha -> entry=32'h0000000a, exactly 8 edges after press.
4. Boundary conditions:
   - 9 pushes -> entry holds the first 8 nibbles, ovf=1.
   - Commit -> ovf=0.
   - Commit with 3 nibbles -> err 1-cycle pulse, instr unchanged, nib_cnt=3.
5. Simultaneous clear+commit press in the FULL state -> entry=0, nib_cnt=0, instr unchanged, no commit_valid.
6. rst asserted 3 cycles into a push's debounce window -> no push recorded, entry=0, instr=RESET_INSTR.
